// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic-to-binary decoder: FSM encoding and
// default operand geometry.
package dsc_pkg;

   localparam int unsigned NUM_INPUTS = 3;
   localparam int unsigned NUM_BITS   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : dsc_pkg

// File: rtl/dsc_s2b_decoder_counter.sv
// Free-running wrap-around counter with synchronous clear and a combinational
// flag for the enabled increment that wraps from all-ones back to zero.
module dsc_s2b_decoder_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic overflow_c
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign overflow_c = en && !clr && (count == {WIDTH{1'b1}});

endmodule : dsc_s2b_decoder_counter

// File: rtl/dsc_s2b_decoder.sv
// Stochastic bitstream to binary decoder: counts ones over a window of
// 2^WIN_BITS accepted bits and offers the saturated count with a handshake.
module dsc_s2b_decoder
   import dsc_pkg::*;
#(
   parameter int unsigned WIN_BITS = NUM_INPUTS * NUM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sn_in,
   input  logic                sn_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic [WIN_BITS-1:0] z,
   output logic                sat,
   output logic                z_valid
);

   state_t            state;
   logic [WIN_BITS:0] ones;
   logic [WIN_BITS:0] ones_inc;
   logic              clr_c;
   logic              accept_c;
   logic              close_c;

   // start clears the counters in IDLE, in ACCUM (abort) and in DONE only
   // together with the consumer handshake.
   always_comb begin
      clr_c    = start && ((state == IDLE) || (state == ACCUM) ||
                           ((state == DONE) && out_ready));
      accept_c = (state == ACCUM) && sn_valid && !start;
      ones_inc = ones + (WIN_BITS + 1)'(sn_in);
   end

   dsc_s2b_decoder_counter #(
      .WIDTH (WIN_BITS)
   ) u_len_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr_c),
      .en         (accept_c),
      .overflow_c (close_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ones    <= '0;
         z       <= '0;
         sat     <= 1'b0;
         z_valid <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ACCUM;
                  busy  <= 1'b1;
                  ones  <= '0;
               end
            end
            ACCUM: begin
               if (start) begin
                  ones <= '0;
               end else if (accept_c) begin
                  ones <= ones_inc;
                  if (close_c) begin
                     // Only a full window of ones reaches 2^WIN_BITS.
                     state   <= DONE;
                     busy    <= 1'b0;
                     z       <= ones_inc[WIN_BITS] ? {WIN_BITS{1'b1}}
                                                   : ones_inc[WIN_BITS-1:0];
                     sat     <= ones_inc[WIN_BITS];
                     z_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  z_valid <= 1'b0;
                  if (start) begin
                     state <= ACCUM;
                     busy  <= 1'b1;
                     ones  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               z_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : dsc_s2b_decoder

// File: tb/tb_dsc_s2b_decoder.sv
// Randomized self-checking bench for dsc_s2b_decoder at WIN_BITS=4, plus a
// smoke instance at WIN_BITS=8.
module tb_dsc_s2b_decoder;

   localparam int unsigned W  = 4;
   localparam int unsigned N  = 1 << W;
   localparam int unsigned W8 = 8;
   localparam int unsigned N8 = 1 << W8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, sn_in, sn_valid, out_ready;
   logic         busy, sat, z_valid;
   logic [W-1:0] z;

   logic          rst8, start8, sn_in8, sn_valid8, out_ready8;
   logic          busy8, sat8, z_valid8;
   logic [W8-1:0] z8;

   int n_tests = 0;
   int n_fail  = 0;

   dsc_s2b_decoder #(.WIN_BITS(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sn_in(sn_in), .sn_valid(sn_valid),
      .out_ready(out_ready), .busy(busy), .z(z), .sat(sat), .z_valid(z_valid)
   );

   dsc_s2b_decoder #(.WIN_BITS(W8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .sn_in(sn_in8), .sn_valid(sn_valid8),
      .out_ready(out_ready8), .busy(busy8), .z(z8), .sat(sat8), .z_valid(z_valid8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: popcount clipped to the largest representable value.
   function automatic int exp_z(input int ones, input int wb);
      return (ones >= (1 << wb)) ? (1 << wb) - 1 : ones;
   endfunction

   function automatic logic [N-1:0] make_pat(input int k);
      logic [N-1:0] p;
      logic         t;
      int           j;
      p = '0;
      for (int i = 0; i < k; i++) p[i] = 1'b1;
      for (int i = N - 1; i > 0; i--) begin
         j    = $urandom_range(i, 0);
         t    = p[i];
         p[i] = p[j];
         p[j] = t;
      end
      return p;
   endfunction

   task automatic open_window(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_open"}, 32'(busy), 32'd1);
   endtask

   // Feeds one full window; expects z_valid to rise exactly after the last bit.
   task automatic run_bits(input string tag, input logic [N-1:0] pat, input int gap);
      int k;
      k = $countones(pat);
      for (int i = 0; i < int'(N); i++) begin
         for (int g = 0; g < gap; g++) begin
            sn_valid = 1'b0;
            sn_in    = 1'($urandom);
            tick();
            check({tag, "_gap_zv"}, 32'(z_valid), 32'd0);
         end
         sn_valid = 1'b1;
         sn_in    = pat[i];
         tick();
         check({tag, "_zv"}, 32'(z_valid), (i == int'(N) - 1) ? 32'd1 : 32'd0);
      end
      sn_valid = 1'b0;
      check({tag, "_z"}, 32'(z), 32'(exp_z(k, W)));
      check({tag, "_sat"}, 32'(sat), (k == int'(N)) ? 32'd1 : 32'd0);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
   endtask

   // Holds in DONE with ignored start/sn_in, then completes the handshake.
   task automatic handshake(input string tag, input int hold, input int ez);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start     = 1'($urandom);
         sn_valid  = 1'b1;
         sn_in     = 1'($urandom);
         tick();
         check({tag, "_hold_zv"}, 32'(z_valid), 32'd1);
         check({tag, "_hold_z"}, 32'(z), 32'(ez));
      end
      start     = 1'b0;
      sn_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ack_zv"}, 32'(z_valid), 32'd0);
      check({tag, "_ack_busy"}, 32'(busy), 32'd0);
      check({tag, "_keep_z"}, 32'(z), 32'(ez));
   endtask

   initial begin
      logic [N-1:0] pat;
      int           k, ones8;
      logic         b;

      rst = 1'b0; start = 1'b0; sn_in = 1'b0; sn_valid = 1'b0; out_ready = 1'b0;
      rst8 = 1'b0; start8 = 1'b0; sn_in8 = 1'b0; sn_valid8 = 1'b0; out_ready8 = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_zv", 32'(z_valid), 32'd0);
      check("rst_z", 32'(z), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      #2 rst = 1'b1; rst8 = 1'b1;
      tick();

      // sn_in in IDLE is ignored
      for (int i = 0; i < 3; i++) begin
         sn_valid = 1'b1;
         sn_in    = 1'($urandom);
         tick();
         check("idle_busy", 32'(busy), 32'd0);
      end
      sn_valid = 1'b0;

      open_window("five");
      run_bits("five", make_pat(5), 0);
      handshake("five", 3, 5);

      open_window("ones");
      run_bits("ones", make_pat(16), 0);
      handshake("ones", 1, 15);

      open_window("zeros");
      run_bits("zeros", make_pat(0), 0);
      handshake("zeros", 0, 0);

      open_window("gaps");
      run_bits("gaps", make_pat(8), 2);
      handshake("gaps", 2, 8);

      // Abort after 7 bits; the aborting cycle also carries a valid one.
      open_window("abort");
      for (int i = 0; i < 7; i++) begin
         sn_valid = 1'b1;
         sn_in    = 1'($urandom);
         tick();
         check("abort_pre_zv", 32'(z_valid), 32'd0);
      end
      start = 1'b1; sn_valid = 1'b1; sn_in = 1'b1;
      tick();
      start = 1'b0; sn_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'd1);
      check("abort_zv", 32'(z_valid), 32'd0);
      run_bits("abort", make_pat(3), 0);
      handshake("abort", 1, 3);

      // Asynchronous reset mid-window, then during DONE.
      open_window("rstacc");
      for (int i = 0; i < 5; i++) begin
         sn_valid = 1'b1; sn_in = 1'b1;
         tick();
      end
      sn_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rstacc_busy", 32'(busy), 32'd0);
      check("rstacc_zv", 32'(z_valid), 32'd0);
      check("rstacc_z", 32'(z), 32'd0);
      #1 rst = 1'b1;
      tick();
      check("rstacc_idle", 32'(busy), 32'd0);
      open_window("rstdone");
      run_bits("rstdone", make_pat(16), 0);
      #2 rst = 1'b0;
      #1;
      check("rstdone_busy", 32'(busy), 32'd0);
      check("rstdone_zv", 32'(z_valid), 32'd0);
      check("rstdone_z", 32'(z), 32'd0);
      check("rstdone_sat", 32'(sat), 32'd0);
      #1 rst = 1'b1;
      tick();
      open_window("ten");
      run_bits("ten", make_pat(10), 0);

      // Back-to-back: ack and start together in DONE.
      out_ready = 1'b1; start = 1'b1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_zv", 32'(z_valid), 32'd0);
      run_bits("b2b", make_pat(12), 0);
      handshake("b2b", 1, 12);

      for (int r = 0; r < 8; r++) begin
         k   = $urandom_range(N, 0);
         pat = make_pat(k);
         open_window("rnd");
         run_bits("rnd", pat, $urandom_range(2, 0));
         handshake("rnd", $urandom_range(3, 0), exp_z(k, W));
      end

      // WIN_BITS=8 smoke: a random window, then an all-ones window.
      for (int pass = 0; pass < 2; pass++) begin
         ones8  = 0;
         start8 = 1'b1;
         tick();
         start8 = 1'b0;
         check("w8_busy", 32'(busy8), 32'd1);
         for (int i = 0; i < int'(N8); i++) begin
            b         = (pass == 1) ? 1'b1 : 1'($urandom);
            ones8    += int'(b);
            sn_valid8 = 1'b1;
            sn_in8    = b;
            tick();
            check("w8_zv", 32'(z_valid8), (i == int'(N8) - 1) ? 32'd1 : 32'd0);
         end
         sn_valid8 = 1'b0;
         check("w8_z", 32'(z8), 32'(exp_z(ones8, W8)));
         check("w8_sat", 32'(sat8), (ones8 == int'(N8)) ? 32'd1 : 32'd0);
         out_ready8 = 1'b1;
         tick();
         out_ready8 = 1'b0;
         check("w8_ack_zv", 32'(z_valid8), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_dsc_s2b_decoder

// File: doc/dsc_s2b_decoder.md
DSC_S2B_DECODER -- requirements
Module: dsc_s2b_decoder

Interface
REQ-001 SHALL have parameter WIN_BITS, default 24, giving a window exponent: the window is 2^WIN_BITS stream bits, matching the 3x8-bit multiplier output width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin a new conversion window.
REQ-005 SHALL have port sn_in, input, 1 bit: serial stochastic bit.
REQ-006 SHALL have port sn_valid, input, 1 bit: sn_in is meaningful this cycle.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts z this cycle.
REQ-008 SHALL have port busy, output, 1 bit: a window is being accumulated.
REQ-009 SHALL have port z, output, WIN_BITS bits: count of ones in the window, saturated.
REQ-010 SHALL have port sat, output, 1 bit: every bit of the window was 1, so z is clamped to all-ones.
REQ-011 SHALL have port z_valid, output, 1 bit: z and sat are stable and offered to the consumer.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-013 IDLE with start=1 SHALL clear the ones counter and the length counter, and move to ACCUM on the next edge.
REQ-014 In ACCUM, a cycle with sn_valid=1 SHALL increment the length counter and, if sn_in=1, the ones counter; a cycle with sn_valid=0 SHALL change no counter.
REQ-015 The window SHALL close on the accepted bit at which the length counter wraps from 2^WIN_BITS-1 to 0, moving the FSM to DONE.
REQ-016 The ones counter SHALL be WIN_BITS+1 bits wide internally.
REQ-017 On entry to DONE, z SHALL be registered as min(ones, 2^WIN_BITS-1), sat SHALL be registered as (ones == 2^WIN_BITS), and z_valid SHALL rise in the same cycle.
REQ-018 Latency from the closing bit's edge to z_valid=1 SHALL be exactly 1 cycle.
REQ-019 DONE SHALL hold z, sat and z_valid until a cycle with out_ready=1, then return to IDLE with z_valid=0 on the next edge.
REQ-020 If out_ready=1 and start=1 arrive together in DONE, the block SHALL go directly to ACCUM with cleared counters, so back-to-back windows incur no idle cycle.
REQ-021 start=1 in ACCUM SHALL abort the current window: counters are cleared, the FSM stays in ACCUM, and no z_valid is produced for the aborted window.
REQ-022 start=0 in DONE SHALL be ignored; start=1 in DONE without out_ready SHALL be ignored.
REQ-023 sn_in SHALL be ignored in IDLE and DONE.
REQ-024 busy SHALL equal (state == ACCUM).
REQ-025 z SHALL keep its last value after the handshake, until the next DONE entry.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE and clear both counters, z, sat, z_valid and busy, regardless of the current state (including mid-window and during DONE).
REQ-027 Release of rst SHALL take effect on the first rising clk edge after deassertion; no output toggles before that edge.

Structure
REQ-028 The FSM state encoding (IDLE, ACCUM, DONE) and the default constants NUM_INPUTS=3 and NUM_BITS=8 SHALL live in a shared package dsc_pkg.
REQ-029 The default SHALL be WIN_BITS = NUM_INPUTS*NUM_BITS.
REQ-030 The length counter SHALL be an instance of the existing counter sub-module (WIDTH=WIN_BITS, en=accepted bit), with its overflow output used as the window-close indication.
REQ-031 The ones counter and the FSM SHALL be local logic.

Verification
REQ-032 Bench runs with WIN_BITS=4 (16-bit window) for speed, plus one smoke run at WIN_BITS=8.
REQ-033 Window of 16 valid bits containing 5 ones -> z=5, sat=0, z_valid exactly 1 cycle after the 16th bit, held until out_ready.
REQ-034 All 16 bits = 1 -> z=15, sat=1; all 16 bits = 0 -> z=0, sat=0.
REQ-035 Stream with sn_valid gaps (valid every third cycle, 16 valid bits, 8 ones) -> z=8, and z_valid rises only after the 16th valid bit.
REQ-036 start pulsed after 7 bits, then 16 bits with 3 ones -> single z_valid with z=3, and none for the aborted window.
REQ-037 rst=0 asserted mid-ACCUM and again during DONE with out_ready=0 -> immediately busy=0, z_valid=0, z=0; then a fresh window of 10 ones -> z=10.
REQ-038 out_ready=1 together with start=1 in DONE -> busy=1 on the next cycle, and the second window with 12 ones gives z=12.
